// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter/sequencer for two requesters in front of the data bus controller.
// Ready bus: ack 3 cycles after req (illegal access: 1 cycle); losing requester holds req, bus stalls time out.
module data_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        bus_rd,
  output logic        bus_wd,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic              last_grant, gnt_q, we_q, err_q;
  logic [1:0]        size_q;
  logic [31:0]       addr_q, wdata_q, rdata_q;
  logic [CNT_W-1:0]  cnt;

  logic              gnt_vld, gnt_id, sel_we, sel_bad, timeout;
  logic [1:0]        sel_size;
  logic [31:0]       sel_addr, sel_wdata;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    gnt_vld   = m0_req | m1_req;
    gnt_id    = (m0_req && m1_req) ? ~last_grant : m1_req;
    sel_we    = gnt_id ? m1_we    : m0_we;
    sel_size  = gnt_id ? m1_size  : m0_size;
    sel_addr  = gnt_id ? m1_addr  : m0_addr;
    sel_wdata = gnt_id ? m1_wdata : m0_wdata;
    sel_bad   = (sel_size == 2'b11) ||
                (sel_size == 2'b01 && sel_addr[0]) ||
                (sel_size == 2'b10 && sel_addr[1:0] != 2'b00);
    timeout   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = sel_bad ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus_ready || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          gnt_q      <= gnt_id;
          last_grant <= gnt_id;
          we_q       <= sel_we;
          size_q     <= sel_size;
          addr_q     <= sel_addr;
          wdata_q    <= sel_wdata;
          rdata_q    <= 32'h0;
          err_q      <= sel_bad;
          cnt        <= '0;
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (bus_ready) begin
            rdata_q <= we_q ? 32'h0 : bus_rdata;
            err_q   <= 1'b0;
          end else if (timeout) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Responses decode from registered state so they never glitch to the requesters.
  always_comb begin
    bus_rd    = (state == ISSUE) && !we_q;
    bus_wd    = (state == ISSUE) && we_q;
    bus_size  = size_q;
    bus_addr  = addr_q;
    bus_wdata = wdata_q;
    busy      = (state != IDLE);
    m0_ack    = 1'b0;
    m0_err    = 1'b0;
    m0_rdata  = 32'h0;
    m1_ack    = 1'b0;
    m1_err    = 1'b0;
    m1_rdata  = 32'h0;
    if (state == RESP) begin
      if (gnt_q) begin
        m1_ack   = 1'b1;
        m1_err   = err_q;
        m1_rdata = rdata_q;
      end else begin
        m0_ack   = 1'b1;
        m0_err   = err_q;
        m0_rdata = rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: latency, round-robin, illegal access, timeout, reset abort, hold-stability.
module tb_data_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [1:0]  m0_size = 0, m1_size = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        bus_rd, bus_wd, bus_ready = 0, busy;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = 0;

  int n_chk  = 0;
  int n_pass = 0;

  data_bus_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .bus_rd(bus_rd), .bus_wd(bus_wd), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int exp_id;

    // reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_strobe", {bus_rd, bus_wd}, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_ack", {m0_ack, m1_ack, m0_err, m1_err}, 0);

    // basic word read with a ready bus
    bus_ready = 1; bus_rdata = 32'hDEADBEEF;
    m0_req = 1; m0_we = 0; m0_size = 2'b10; m0_addr = 32'h10;
    tick();
    check("rd_strobe_c1", {bus_rd, bus_wd}, 2'b10);
    check("rd_addr_c1", bus_addr, 32'h10);
    tick();
    check("rd_strobe_c2", {bus_rd, bus_wd}, 0);
    check("rd_ack_c2", m0_ack, 0);
    tick();
    check("rd_ack_c3", m0_ack, 1);
    check("rd_rdata_c3", m0_rdata, 32'hDEADBEEF);
    check("rd_err_c3", m0_err, 0);
    check("rd_m1_ack_c3", m1_ack, 0);
    m0_req = 0;
    tick();
    check("rd_busy_c4", busy, 0);
    check("rd_ack_c4", m0_ack, 0);

    // round-robin with both requesters continuously asking
    do_reset();
    bus_ready = 1; bus_rdata = 32'h12345678;
    m0_req = 1; m0_we = 1; m0_size = 2'b10; m0_addr = 32'h4; m0_wdata = 32'h55;
    m1_req = 1; m1_we = 0; m1_size = 2'b10; m1_addr = 32'h8;
    for (int i = 0; i < 4; i++) begin
      exp_id = i % 2;
      n = 0;
      tick();
      while (!(bus_rd || bus_wd) && n < 10) begin tick(); n++; end
      check("rr_strobe_seen", bus_rd | bus_wd, 1);
      check("rr_strobe_kind", {bus_rd, bus_wd}, (exp_id == 0) ? 2'b01 : 2'b10);
      check("rr_addr", bus_addr, (exp_id == 0) ? 32'h4 : 32'h8);
      check("rr_wdata", bus_wdata, (exp_id == 0) ? 32'h55 : 32'h0);
      n = 0;
      while (!(m0_ack || m1_ack) && n < 10) begin tick(); n++; end
      check("rr_m0_ack", m0_ack, (exp_id == 0) ? 1 : 0);
      check("rr_m1_ack", m1_ack, (exp_id == 1) ? 1 : 0);
      check("rr_rdata", (exp_id == 0) ? m0_rdata : m1_rdata, (exp_id == 0) ? 32'h0 : 32'h12345678);
    end
    m0_req = 0; m1_req = 0;
    tick();

    // illegal accesses from m1 are answered locally in one cycle
    m1_we = 0;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin m1_size = 2'b10; m1_addr = 32'h6; end
        1: begin m1_size = 2'b01; m1_addr = 32'h3; end
        default: begin m1_size = 2'b11; m1_addr = 32'h0; end
      endcase
      m1_req = 1;
      tick();
      check("ill_ack", m1_ack, 1);
      check("ill_err", m1_err, 1);
      check("ill_rdata", m1_rdata, 0);
      check("ill_strobe_c1", {bus_rd, bus_wd}, 0);
      m1_req = 0;
      tick();
      check("ill_strobe_c2", {bus_rd, bus_wd}, 0);
      check("ill_busy_c2", busy, 0);
    end

    // timeout with a stalled bus
    bus_ready = 0; bus_rdata = 32'hFFFF0000;
    m0_req = 1; m0_we = 0; m0_size = 2'b10; m0_addr = 32'h20;
    n = 1;
    tick();
    while (m0_ack !== 1'b1 && n < 40) begin tick(); n++; end
    check("tmo_latency", n, 18);
    check("tmo_err", m0_err, 1);
    check("tmo_rdata", m0_rdata, 0);
    m0_req = 0;
    tick();
    check("tmo_busy_after", busy, 0);

    // reset in the middle of a WAIT aborts without ack
    m0_req = 1; m0_we = 0; m0_size = 2'b10; m0_addr = 32'h30;
    tick(); tick(); tick();
    check("abort_busy_pre", busy, 1);
    rst = 1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_ack", m0_ack, 0);
    check("abort_addr", bus_addr, 0);
    rst = 0;
    bus_ready = 1; bus_rdata = 32'hCAFEF00D;
    m1_req = 1; m1_we = 0; m1_size = 2'b10; m1_addr = 32'h8;
    tick();
    check("post_rst_strobe", {bus_rd, bus_wd}, 2'b10);
    check("post_rst_addr", bus_addr, 32'h30);
    tick(); tick();
    check("post_rst_m0_ack", m0_ack, 1);
    check("post_rst_m0_rdata", m0_rdata, 32'hCAFEF00D);
    check("post_rst_m1_ack0", m1_ack, 0);
    m0_req = 0;
    tick(); tick();
    check("post_rst_m1_addr", bus_addr, 32'h8);
    tick(); tick();
    check("post_rst_m1_ack", m1_ack, 1);
    m1_req = 0;
    tick();

    // latched transaction is stable against request changes during WAIT
    bus_ready = 0; bus_rdata = 32'h777;
    m0_req = 1; m0_we = 1; m0_size = 2'b00; m0_addr = 32'h21; m0_wdata = 32'hAB;
    tick();
    check("hold_wd", {bus_rd, bus_wd}, 2'b01);
    check("hold_wdata", bus_wdata, 32'hAB);
    tick();
    m0_we = 0; m0_size = 2'b10; m0_addr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_addr", bus_addr, 32'h21);
      check("hold_size", bus_size, 2'b00);
      check("hold_strobe", {bus_rd, bus_wd}, 0);
    end
    bus_ready = 1;
    tick();
    check("hold_ack", m0_ack, 1);
    check("hold_wr_rdata", m0_rdata, 0);
    check("hold_addr_ack", bus_addr, 32'h21);
    m0_req = 0;
    tick();
    m0_req = 1;
    tick();
    check("new_rd_strobe", {bus_rd, bus_wd}, 2'b10);
    check("new_addr", bus_addr, 32'h40);
    check("new_size", bus_size, 2'b10);
    tick(); tick();
    check("new_ack", m0_ack, 1);
    check("new_rdata", m0_rdata, 32'h777);
    m0_req = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the data bus controller (on-chip RAM, DBC registers, GPIO).
- Requester 0 is the core load/store unit; requester 1 is the debug/program loader.
- Arbitrates round-robin, latches the winning transaction, and drives a one-cycle rd/wd strobe to the bus controller.
- Waits for bus ready with a timeout, then returns read data, ack and error to the winner. Misaligned or illegal-size accesses are rejected locally and never reach the bus.

Parameters:
TIMEOUT_CYCLES, 16, max WAIT cycles before a transaction is aborted with error (≥2)
CNT_W, 5, width of timeout counter (must hold TIMEOUT_CYCLES)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
m0_req  input  1  requester 0 request, held until m0_ack
m0_we  input  1  1=write, 0=read
m0_size  input  2  00 byte, 01 half, 10 word, 11 illegal
m0_addr  input  32  byte address
m0_wdata  input  32  write data, LSB-justified
m0_ack  output  1  one-cycle completion pulse
m0_err  output  1  valid with m0_ack: misaligned/illegal size/timeout
m0_rdata  output  32  read data, valid with m0_ack
m1_req, m1_we, m1_size, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata  same as m0_* for requester 1
bus_rd  output  1  read strobe to bus controller
bus_wd  output  1  write strobe to bus controller
bus_size  output  2  latched size, drives both size_in and size_out
bus_addr  output  32  latched address, drives both addr_in and addr_out
bus_wdata  output  32  latched write data
bus_rdata  input  32  bus controller read data
bus_ready  input  1  bus controller ready
busy  output  1  high in every state except IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset (rst=1 at edge):
  - state=IDLE, last_grant=1, so m0 wins the first tie.
  - All outputs 0; latched addr/size/wdata/rdata cleared to 0; timeout counter 0.
  - Reset mid-transaction aborts it with no ack.
- IDLE:
  - If neither req is high, stay.
  - If one req is high, grant it.
  - If both are high, grant the requester that was NOT last_grant (round-robin).
  - On grant, latch we/size/addr/wdata and the grant id, and update last_grant.
  - Legal-size, aligned request → ISSUE.
  - Illegal request → RESP with err=1 and no bus strobe. Illegal means size=11, half with addr[0]=1, or word with addr[1:0]≠0.
- ISSUE: exactly one cycle. bus_rd=!we or bus_wd=we is asserted; bus_addr/size/wdata are held. Next state WAIT, counter cleared.
- WAIT:
  - bus_addr/size/wdata stay stable; strobes are 0.
  - bus_ready=1 at an edge → capture bus_rdata (reads only; writes capture 0), go to RESP with err=0.
  - Otherwise the counter increments. When it equals TIMEOUT_CYCLES-1 without ready → RESP with err=1, rdata=0.
- RESP: exactly one cycle.
  - The granted mN_ack=1, mN_err and mN_rdata are driven; all other responses are 0.
  - Next state IDLE.
  - Requests are ignored in RESP.
  - A requester must drop req at the edge where it sees ack. A req still high in IDLE is treated as a new request.
- Latency with a ready bus: req high in cycle 0 → strobe in cycle 1 → WAIT in cycle 2 → ack in cycle 3. Ack is 2 cycles after the strobe; the minimum round trip is 4 cycles per transaction.
- Illegal access: ack with err in cycle 1.
- Outputs are registered; mN_rdata/err are meaningful only while mN_ack=1 and 0 otherwise.
- The non-granted requester sees no ack and must keep req asserted.
- A req change during ISSUE/WAIT has no effect on the latched transaction.
- Strobes are never asserted outside ISSUE; at most one of bus_rd/bus_wd is high in any cycle.

Test Plan:
- Reset, then m0 read word addr=0x10, bus_ready=1, bus_rdata=0xDEADBEEF → bus_rd pulse in cycle 1 only, bus_addr=0x10; m0_ack in cycle 3 with m0_rdata=0xDEADBEEF, m0_err=0.
- m0 and m1 both request continuously (m0 write 0x4 data 0x55, m1 read 0x8), each re-requesting after ack → grants alternate m0, m1, m0, m1; bus_wd/bus_rd alternate, and no ack ever goes to the wrong port.
- m1 word read addr=0x6, then half read addr=0x3, then size=11 → m1_ack with m1_err=1 one cycle after each request; bus_rd/bus_wd stay 0 throughout.
- m0 read with bus_ready held 0, TIMEOUT_CYCLES=16 → m0_ack with m0_err=1 and m0_rdata=0 after 16 WAIT cycles; busy falls the cycle after the ack.
- rst asserted in WAIT with m0 pending → next cycle state IDLE, no m0_ack, busy=0. After deassert, m0 and m1 requesting together → m0 granted first.
- m0 byte write addr=0x21 data 0xAB, and a req/addr change during WAIT → bus_addr stays 0x21 and bus_size stays 00 until the ack; the changed request is serviced afterwards.
